// File: rtl/stack_arbiter.sv
// Two-client round-robin arbiter in front of a shared LIFO stack; screens push-when-full / pop-when-empty.
// Latency: request sampled in IDLE at cycle N, stack strobe at N+1, pop data captured at N+2, ack at N+3.
// Backpressure: one transaction in flight; a client holds req until its ack, the other waits in IDLE.
module stack_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_empty,
    input  logic             stk_full
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             last_q,  last_d;   // client granted most recently
    logic             sel_q,   sel_d;    // client owning the current transaction
    logic             op_q,    op_d;     // 0 = push, 1 = pop
    logic [WIDTH-1:0] data_q,  data_d;
    logic             err_q,   err_d;    // operation rejected by flag screening
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic grant_vld;
    logic grant_sel;
    logic legal;

    // Arbitration: a lone requester wins outright, a tie goes to the client that was not served last
    always_comb begin
        grant_vld = req0 | req1;
        grant_sel = (req0 & req1) ? ~last_q : req1;
        legal     = op_q ? ~stk_empty : ~stk_full;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transaction walks IDLE -> ISSUE -> CAPTURE -> DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: latch the granted request, record rejection, capture popped word
    always_comb begin
        last_d  = last_q;
        sel_d   = sel_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    sel_d  = grant_sel;
                    last_d = grant_sel;
                    op_d   = grant_sel ? op1 : op0;
                    data_d = grant_sel ? wdata1 : wdata0;
                end
            end
            ISSUE: begin
                // flags are honoured only as seen in this cycle
                err_d = ~legal;
            end
            CAPTURE: begin
                // stack output is valid the cycle after the pop edge, i.e. now
                if (op_q && !err_q) begin
                    rdata_d = stk_data_out;
                end
            end
            DONE: begin
                err_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            op_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            last_q  <= last_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from state and owner; strobes additionally gated by this cycle's flags
    always_comb begin
        ack0        = (state_q == DONE) & ~sel_q;
        ack1        = (state_q == DONE) &  sel_q;
        err0        = (state_q == DONE) & ~sel_q & err_q;
        err1        = (state_q == DONE) &  sel_q & err_q;
        stk_push    = (state_q == ISSUE) & ~op_q & legal;
        stk_pop     = (state_q == ISSUE) &  op_q & legal;
        stk_data_in = data_q;
        rdata       = rdata_q;
    end

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, op0, op1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata;
    logic       stk_push, stk_pop;
    logic [7:0] stk_data_in, stk_data_out;
    logic       stk_empty, stk_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .stk_empty(stk_empty), .stk_full(stk_full)
    );

    // Environment: depth-8 LIFO with registered output, reset by the same rst
    logic [7:0] mem [8];
    int         sp;
    int         bad_cmd;
    assign stk_empty = (sp == 0);
    assign stk_full  = (sp == 8);

    always @(posedge clk) begin
        if (rst) begin
            sp           <= 0;
            stk_data_out <= 8'h00;
        end else begin
            if ((stk_push && sp == 8) || (stk_pop && sp == 0) || (stk_push && stk_pop))
                bad_cmd <= bad_cmd + 1;
            if (stk_push && sp < 8) begin
                mem[sp] <= stk_data_in;
                sp      <= sp + 1;
            end else if (stk_pop && sp > 0) begin
                stk_data_out <= mem[sp-1];
                sp           <= sp - 1;
            end
        end
    end

    // Reference model: stack contents, last popped word, round-robin owner
    logic [7:0] m_stk [$];
    logic [7:0] m_rdata;
    bit         m_last;

    task automatic model_reset();
        m_stk.delete();
        m_rdata = 8'h00;
        m_last  = 1'b1;
    endtask

    task automatic model_apply(input bit client, input bit op, input logic [7:0] d,
                               output bit e, output logic [7:0] rd);
        m_last = client;
        if (!op) begin
            if (m_stk.size() < 8) begin m_stk.push_back(d); e = 1'b0; end
            else e = 1'b1;
        end else begin
            if (m_stk.size() > 0) begin m_rdata = m_stk.pop_back(); e = 1'b0; end
            else e = 1'b1;
        end
        rd = m_rdata;
    endtask

    // Observations from the last drive() call
    int         o_ack [2];
    bit         o_err [2];
    logic [7:0] o_rd  [2];
    int         o_npush, o_npop, o_push_cyc, o_pop_cyc, o_both, o_stray;
    logic [7:0] o_push_dat;

    // Raise requests in an IDLE cycle (cycle 0), watch until every requester is acked, return in IDLE
    task automatic drive(input bit r0, input bit p0, input logic [7:0] d0,
                         input bit r1, input bit p1, input logic [7:0] d1);
        o_ack[0] = -1; o_ack[1] = -1; o_err[0] = 0; o_err[1] = 0;
        o_rd[0] = 8'hxx; o_rd[1] = 8'hxx;
        o_npush = 0; o_npop = 0; o_push_cyc = -1; o_pop_cyc = -1;
        o_both = 0; o_stray = 0; o_push_dat = 8'hxx;
        req0 = r0; op0 = p0; wdata0 = d0;
        req1 = r1; op1 = p1; wdata1 = d1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (stk_push) begin
                if (o_npush == 0) begin o_push_cyc = cyc; o_push_dat = stk_data_in; end
                o_npush++;
            end
            if (stk_pop) begin
                if (o_npop == 0) o_pop_cyc = cyc;
                o_npop++;
            end
            if (stk_push && stk_pop) o_both++;
            if (ack0) begin
                if (!r0 || o_ack[0] != -1) o_stray++;
                o_ack[0] = cyc; o_err[0] = err0; o_rd[0] = rdata; req0 = 1'b0;
            end else if (err0) o_stray++;
            if (ack1) begin
                if (!r1 || o_ack[1] != -1) o_stray++;
                o_ack[1] = cyc; o_err[1] = err1; o_rd[1] = rdata; req1 = 1'b0;
            end else if (err1) o_stray++;
            if ((!r0 || o_ack[0] != -1) && (!r1 || o_ack[1] != -1)) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; op0 = 1'b1; op1 = 1'b0;
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        repeat (2) @(negedge clk);
        checks++;
        if ({ack0, ack1, err0, err1, stk_push, stk_pop} !== 6'b0 || rdata !== 8'h00 || stk_data_in !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: ack/err/strobes=%b rdata=%h data_in=%h, required all 0",
                     {ack0, ack1, err0, err1, stk_push, stk_pop}, rdata, stk_data_in);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ack0, ack1, err0, err1, stk_push, stk_pop} !== 6'b0 || rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset_release cycle %0d: ack/err/strobes=%b rdata=%h, required 0",
                         i, {ack0, ack1, err0, err1, stk_push, stk_pop}, rdata);
            end
        end
    endtask

    task automatic test_single_push_pop();
        bit e; logic [7:0] rd;
        do_reset();
        drive(1, 0, 8'h03, 0, 0, 8'h00);
        model_apply(0, 0, 8'h03, e, rd);
        checks++;
        if (o_push_cyc !== 1 || o_push_dat !== 8'h03 || o_npush !== 1) begin
            errors++;
            $display("FAIL single_push_strobe: cyc=%0d data=%h n=%0d, required cyc=1 data=03 n=1",
                     o_push_cyc, o_push_dat, o_npush);
        end
        checks++;
        if (o_ack[0] !== 3 || o_err[0] !== 1'b0 || o_stray !== 0) begin
            errors++;
            $display("FAIL single_push_ack: ack_cyc=%0d err=%b stray=%0d, required 3/0/0",
                     o_ack[0], o_err[0], o_stray);
        end
        drive(1, 1, 8'h00, 0, 0, 8'h00);
        model_apply(0, 1, 8'h00, e, rd);
        checks++;
        if (o_ack[0] !== 3 || o_err[0] !== e || o_rd[0] !== rd || o_pop_cyc !== 1) begin
            errors++;
            $display("FAIL single_pop: ack_cyc=%0d err=%b rdata=%h pop_cyc=%0d, required 3/%b/%h/1",
                     o_ack[0], o_err[0], o_rd[0], o_pop_cyc, e, rd);
        end
    endtask

    task automatic test_tie_round_robin();
        bit e; logic [7:0] rd;
        do_reset();
        drive(1, 0, 8'h11, 1, 0, 8'h22);
        model_apply(0, 0, 8'h11, e, rd);
        model_apply(1, 0, 8'h22, e, rd);
        checks++;
        if (o_ack[0] !== 3 || o_ack[1] !== 7 || o_err[0] !== 1'b0 || o_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL tie_push: ack0_cyc=%0d ack1_cyc=%0d err=%b%b, required 3/7/00",
                     o_ack[0], o_ack[1], o_err[0], o_err[1]);
        end
        drive(1, 1, 8'h00, 1, 1, 8'h00);
        model_apply(0, 1, 8'h00, e, rd);
        model_apply(1, 1, 8'h00, e, rd);
        checks++;
        if (o_ack[0] !== 3 || o_ack[1] !== 7 || o_rd[0] !== 8'h22 || o_rd[1] !== 8'h11) begin
            errors++;
            $display("FAIL tie_pop: ack cyc %0d/%0d rdata %h/%h, required 3/7 22/11",
                     o_ack[0], o_ack[1], o_rd[0], o_rd[1]);
        end
    endtask

    task automatic test_full_empty();
        bit e; logic [7:0] rd;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, 8'(i), 0, 0, 8'h00);
            model_apply(0, 0, 8'(i), e, rd);
            checks++;
            if (o_ack[0] !== 3 || o_err[0] !== 1'b0 || o_npush !== 1) begin
                errors++;
                $display("FAIL fill_push %0d: ack_cyc=%0d err=%b npush=%0d, required 3/0/1",
                         i, o_ack[0], o_err[0], o_npush);
            end
        end
        drive(1, 0, 8'h09, 0, 0, 8'h00);
        model_apply(0, 0, 8'h09, e, rd);
        checks++;
        if (o_ack[0] !== 3 || o_err[0] !== 1'b1 || o_npush !== 0) begin
            errors++;
            $display("FAIL push_full: ack_cyc=%0d err=%b npush=%0d, required 3/1/0",
                     o_ack[0], o_err[0], o_npush);
        end
        for (int i = 8; i >= 1; i--) begin
            drive(1, 1, 8'h00, 0, 0, 8'h00);
            model_apply(0, 1, 8'h00, e, rd);
            checks++;
            if (o_ack[0] !== 3 || o_err[0] !== 1'b0 || o_rd[0] !== 8'(i)) begin
                errors++;
                $display("FAIL drain_pop %0d: ack_cyc=%0d err=%b rdata=%h, required 3/0/%h",
                         i, o_ack[0], o_err[0], o_rd[0], 8'(i));
            end
        end
        drive(1, 1, 8'h00, 0, 0, 8'h00);
        model_apply(0, 1, 8'h00, e, rd);
        checks++;
        if (o_ack[0] !== 3 || o_err[0] !== 1'b1 || o_npop !== 0 || o_rd[0] !== 8'h01) begin
            errors++;
            $display("FAIL pop_empty: ack_cyc=%0d err=%b npop=%0d rdata=%h, required 3/1/0/01",
                     o_ack[0], o_err[0], o_npop, o_rd[0]);
        end
        checks++;
        if (bad_cmd !== 0) begin
            errors++;
            $display("FAIL stack_protocol: illegal commands=%0d, required 0", bad_cmd);
        end
    endtask

    task automatic test_reset_mid_op();
        bit e; logic [7:0] rd;
        int seen;
        do_reset();
        drive(0, 0, 8'h00, 1, 0, 8'h55);
        model_apply(1, 0, 8'h55, e, rd);
        req0 = 1'b1; op0 = 1'b1; wdata0 = 8'h00;
        @(negedge clk);                       // ISSUE of the pop
        checks++;
        if (stk_pop !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue: stk_pop=%b, required 1", stk_pop);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0;
        model_reset();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ack0 || ack1 || err0 || err1 || stk_push || stk_pop) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL midrst_quiet: activity cycles=%0d rdata=%h, required 0/00", seen, rdata);
        end
        drive(1, 0, 8'hA1, 1, 0, 8'hB2);
        model_apply(0, 0, 8'hA1, e, rd);
        model_apply(1, 0, 8'hB2, e, rd);
        checks++;
        if (o_ack[0] !== 3 || o_ack[1] !== 7) begin
            errors++;
            $display("FAIL midrst_tie: ack0_cyc=%0d ack1_cyc=%0d, required 3/7", o_ack[0], o_ack[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit e; logic [7:0] rd;
        bit cur_op; logic [7:0] cur_d;
        int k, both, stray;
        k = 0; both = 0; stray = 0;
        cur_op = 1'b0; cur_d = 8'($urandom);
        req1 = 1'b1; op1 = cur_op; wdata1 = cur_d;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (stk_push && stk_pop) both++;
            if (ack0 || err0) stray++;
            if (ack1) begin
                model_apply(1, cur_op, cur_d, e, rd);
                checks++;
                if (cyc !== 3 + 4 * k || err1 !== e || rdata !== rd) begin
                    errors++;
                    $display("FAIL b2b_txn %0d: ack_cyc=%0d err=%b rdata=%h, required %0d/%b/%h",
                             k, cyc, err1, rdata, 3 + 4 * k, e, rd);
                end
                k++;
                if (k == 8) begin req1 = 1'b0; break; end
                cur_op = ~cur_op; cur_d = 8'($urandom);
                op1 = cur_op; wdata1 = cur_d;
            end
        end
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (k !== 8 || both !== 0 || stray !== 0) begin
            errors++;
            $display("FAIL b2b_summary: acks=%0d both=%0d client0_activity=%0d, required 8/0/0",
                     k, both, stray);
        end
    endtask

    task automatic test_random();
        bit r0, r1, p0, p1, first;
        logic [7:0] d0, d1;
        int x_ack [2]; bit x_err [2]; logic [7:0] x_rd [2];
        int legal_cnt;
        bit e; logic [7:0] rd;
        for (int it = 0; it < 40; it++) begin
            r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            p0 = 1'($urandom_range(0, 1)); p1 = 1'($urandom_range(0, 1));
            d0 = 8'($urandom); d1 = 8'($urandom);
            first = (r0 && r1) ? ~m_last : r1;
            legal_cnt = 0;
            x_ack[0] = -1; x_ack[1] = -1;
            x_err[0] = 0; x_err[1] = 0; x_rd[0] = 8'hxx; x_rd[1] = 8'hxx;
            model_apply(first, first ? p1 : p0, first ? d1 : d0, e, rd);
            x_ack[first] = 3; x_err[first] = e; x_rd[first] = rd;
            if (!e) legal_cnt++;
            if (r0 && r1) begin
                model_apply(~first, first ? p0 : p1, first ? d0 : d1, e, rd);
                x_ack[~first] = 7; x_err[~first] = e; x_rd[~first] = rd;
                if (!e) legal_cnt++;
            end
            drive(r0, p0, d0, r1, p1, d1);
            checks++;
            if (o_ack[0] !== x_ack[0] || o_ack[1] !== x_ack[1] ||
                (r0 && (o_err[0] !== x_err[0] || o_rd[0] !== x_rd[0])) ||
                (r1 && (o_err[1] !== x_err[1] || o_rd[1] !== x_rd[1])) ||
                o_npush + o_npop !== legal_cnt || o_both !== 0 || o_stray !== 0) begin
                errors++;
                $display("FAIL random %0d: ack %0d/%0d err %b/%b rd %h/%h strobes %0d stray %0d, required ack %0d/%0d err %b/%b rd %h/%h strobes %0d stray 0",
                         it, o_ack[0], o_ack[1], o_err[0], o_err[1], o_rd[0], o_rd[1],
                         o_npush + o_npop, o_stray, x_ack[0], x_ack[1], x_err[0], x_err[1],
                         x_rd[0], x_rd[1], legal_cnt);
            end
        end
        checks++;
        if (bad_cmd !== 0) begin
            errors++;
            $display("FAIL random_protocol: illegal commands=%0d, required 0", bad_cmd);
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        wdata0 = 8'h00; wdata1 = 8'h00;
        bad_cmd = 0; sp = 0;
        model_reset();
        test_reset();
        test_single_push_pop();
        test_tie_round_robin();
        test_full_empty();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
